// File: rtl/wishbone_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole bus cycle,
// with a watchdog that ends unacknowledged strobes and flags an error to the owner.
module wishbone_arbiter2 #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [7:0]  m0_dat_i,
  output logic [7:0]  m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [15:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic [7:0]  m1_dat_i,
  output logic [7:0]  m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [15:0] s_adr_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic [7:0]  s_dat_o,
  input  logic [7:0]  s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state;
  logic             last_gnt;   // 0 = m0 owned last, 1 = m1 owned last
  logic [CNT_W-1:0] wdog;
  logic [CNT_W-1:0] wdog_nx;

  logic        ack_in;
  logic        own_cyc;
  logic        own_stb;
  logic        own_we;
  logic [15:0] own_adr;
  logic [7:0]  own_dat;
  logic        req_stb;
  logic        timeout_hit;
  logic        owner_ack;

  // Only a clean logic 1 counts as an acknowledge; Z or X from an undriven bus does not.
  assign ack_in = (s_ack_i === 1'b1);

  // Select the current owner's request signals; nothing is selected while idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    case (state)
      GNT0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
      end
      GNT1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  // A strobe only counts while the owner still holds cyc; the bus falls to 0 when cyc drops.
  assign req_stb     = own_cyc & own_stb;
  assign timeout_hit = req_stb & ~ack_in & (wdog == WD_LAST);
  assign owner_ack   = req_stb & ack_in;

  assign s_cyc_o = own_cyc;
  assign s_stb_o = req_stb & ~timeout_hit;
  assign s_we_o  = own_cyc & own_we;
  assign s_adr_o = own_cyc ? own_adr : 16'h0000;
  assign s_dat_o = own_cyc ? own_dat : 8'h00;

  assign m0_ack_o = (state == GNT0) & owner_ack;
  assign m1_ack_o = (state == GNT1) & owner_ack;
  assign m0_err_o = (state == GNT0) & timeout_hit;
  assign m1_err_o = (state == GNT1) & timeout_hit;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign gnt_o = {state == GNT1, state == GNT0};

  // Watchdog next value: count unacknowledged strobe cycles, saturating at the last count.
  always_comb begin
    wdog_nx = '0;
    if (req_stb && !ack_in && !timeout_hit) begin
      wdog_nx = (wdog < WD_LAST) ? wdog + CNT_W'(1) : wdog;
    end
  end

  // Grant FSM with round-robin tie break and watchdog register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wdog     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
            state <= GNT0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            last_gnt <= 1'b0;
            wdog     <= '0;
            state    <= m1_cyc_i ? GNT1 : IDLE;
          end else begin
            wdog <= wdog_nx;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            last_gnt <= 1'b1;
            wdog     <= '0;
            state    <= m0_cyc_i ? GNT0 : IDLE;
          end else begin
            wdog <= wdog_nx;
          end
        end
        default: begin
          state <= IDLE;
          wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Self-checking bench for wishbone_arbiter2: directed scenarios plus a randomized
// run compared against a cycle-level ownership/timeout model.
module tb_wishbone_arbiter2;

  localparam int TIMEOUT = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] m0_adr_i, m1_adr_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i;
  logic        m1_we_i, m1_stb_i, m1_cyc_i;
  logic [7:0]  m0_dat_i, m1_dat_i;
  logic [7:0]  m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [15:0] s_adr_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [7:0]  s_dat_o;
  logic [7:0]  s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  wishbone_arbiter2 #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    m0_adr_i = '0; m0_we_i = 0; m0_stb_i = 0; m0_cyc_i = 0; m0_dat_i = '0;
    m1_adr_i = '0; m1_we_i = 0; m1_stb_i = 0; m1_cyc_i = 0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'bz;
  endtask

  // Advance to just after the next rising edge.
  task automatic clk_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    clk_step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h1234; s_dat_i = 8'hA5; s_ack_i = 1'b1;
    #1 rst_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #2;
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
    n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); end
    n_checks++; if (s_adr_o !== 16'h0000) begin n_fail++; $display("FAIL reset_adr: got %h want 0000", s_adr_o); end
    n_checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_ackerr: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
    n_checks++; if (m0_dat_o !== 8'hA5 || m1_dat_o !== 8'hA5) begin n_fail++; $display("FAIL reset_dat: got %h/%h want a5", m0_dat_o, m1_dat_o); end
    do_reset();
  endtask

  task automatic test_single();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h1A05; m1_we_i = 1; m1_dat_i = 8'h5C;
    #1;
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL single_latency: got %b want 00", gnt_o); end
    clk_step();
    n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL single_gnt: got %b want 10", gnt_o); end
    n_checks++; if (s_adr_o !== 16'h1A05 || s_dat_o !== 8'h5C) begin n_fail++; $display("FAIL single_bus: got %h/%h want 1a05/5c", s_adr_o, s_dat_o); end
    n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) begin n_fail++; $display("FAIL single_ctl: got %b want 111", {s_cyc_o, s_stb_o, s_we_o}); end
    n_checks++; if (m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_noack: got %b want 0", m1_ack_o); end
    s_ack_i = 1'b1; #1;
    n_checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_ack: got m1=%b m0=%b want 1/0", m1_ack_o, m0_ack_o); end
    clk_step();
    s_ack_i = 1'bz; m1_cyc_i = 0; m1_stb_i = 0; #1;
    n_checks++; if (s_cyc_o !== 1'b0 || s_adr_o !== 16'h0000) begin n_fail++; $display("FAIL single_drop_bus: got cyc=%b adr=%h want 0/0000", s_cyc_o, s_adr_o); end
    clk_step();
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", gnt_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    clk_step();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL simul_first: got %b want 01", gnt_o); end
    m0_cyc_i = 0;
    clk_step();
    n_checks++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL simul_handover: got gnt=%b cyc=%b want 10/1", gnt_o, s_cyc_o); end
    m1_cyc_i = 0;
    clk_step();
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL simul_idle: got %b want 00", gnt_o); end
    m0_cyc_i = 1; m1_cyc_i = 1;
    clk_step();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL simul_rr: got %b want 01", gnt_o); end
    m0_cyc_i = 0; m1_cyc_i = 0;
    clk_step(); clk_step();
  endtask

  task automatic test_hold();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    m0_cyc_i = 1; m0_adr_i = 16'h0040;
    clk_step();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL hold_gnt: got %b want 01", gnt_o); end
    m1_cyc_i = 1; m1_stb_i = 1;
    for (int i = 0; i < 3; i++) begin
      m0_stb_i = 1; s_dat_i = vals[i]; s_ack_i = 1'b1; #1;
      n_checks++; if (m0_dat_o !== vals[i] || m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL hold_read%0d: got dat=%h ack=%b want %h/1", i, m0_dat_o, m0_ack_o, vals[i]); end
      n_checks++; if (m1_ack_o !== 1'b0 || gnt_o !== 2'b01) begin n_fail++; $display("FAIL hold_other%0d: got m1_ack=%b gnt=%b want 0/01", i, m1_ack_o, gnt_o); end
      clk_step();
      m0_stb_i = 0; s_ack_i = 1'bz; #1;
      n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL hold_gap%0d: got %b want 01", i, gnt_o); end
      clk_step();
    end
    m0_cyc_i = 0;
    clk_step();
    n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL hold_handover: got %b want 10", gnt_o); end
    m1_cyc_i = 0; m1_stb_i = 0;
    clk_step(); clk_step();
  endtask

  task automatic test_timeout();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'hF000; s_ack_i = 1'bz;
    clk_step();
    for (int k = 1; k <= TIMEOUT; k++) begin
      #1;
      n_checks++;
      if (m0_err_o !== (k == TIMEOUT) || s_stb_o !== (k != TIMEOUT) || m0_ack_o !== 1'b0) begin
        n_fail++; $display("FAIL timeout_cyc%0d: got err=%b stb=%b ack=%b", k, m0_err_o, s_stb_o, m0_ack_o);
      end
      clk_step();
    end
    #1;
    n_checks++; if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin n_fail++; $display("FAIL timeout_after: got err=%b stb=%b want 0/1", m0_err_o, s_stb_o); end
    m0_cyc_i = 0; m0_stb_i = 0;
    clk_step();
  endtask

  task automatic test_ack_edge();
    m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1'bz;
    clk_step();
    for (int k = 1; k < TIMEOUT; k++) clk_step();
    s_ack_i = 1'b1; #1;
    n_checks++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin n_fail++; $display("FAIL ackedge_win: got ack=%b err=%b stb=%b want 1/0/1", m0_ack_o, m0_err_o, s_stb_o); end
    clk_step();
    s_ack_i = 1'bz;
    // Watchdog restarted by the ack: a full TIMEOUT strobe cycles are needed again.
    for (int k = 1; k <= TIMEOUT; k++) begin
      #1;
      n_checks++; if (m0_err_o !== (k == TIMEOUT)) begin n_fail++; $display("FAIL ackedge_restart%0d: got err=%b", k, m0_err_o); end
      clk_step();
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    clk_step();
  endtask

  task automatic test_async_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0008;
    clk_step();
    s_ack_i = 1'b1; #1;
    n_checks++; if (gnt_o !== 2'b01 || m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got gnt=%b ack=%b want 01/1", gnt_o, m0_ack_o); end
    #2 rst_i = 1'b0; #1;
    n_checks++; if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL areset_now: got gnt=%b cyc=%b ack=%b want 00/0/0", gnt_o, s_cyc_o, m0_ack_o); end
    do_reset();
  endtask

  task automatic test_random();
    int owner, last, wd;
    int phase;
    bit a, oc, os, ow, other_cyc, act, to;
    logic [15:0] oadr;
    logic [7:0]  odat;
    logic [48:0] got, exp;
    do_reset();
    owner = 0; last = 1; wd = 0;
    for (int n = 0; n < 900; n++) begin
      phase = (n / 60) % 3;
      if ($urandom_range(7) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(7) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & ((phase == 1) || ($urandom_range(3) != 0));
      m1_stb_i = m1_cyc_i & ((phase == 1) || ($urandom_range(3) != 0));
      m0_adr_i = 16'($urandom); m1_adr_i = 16'($urandom);
      m0_dat_i = 8'($urandom);  m1_dat_i = 8'($urandom);
      m0_we_i = 1'($urandom);   m1_we_i = 1'($urandom);
      s_dat_i = 8'($urandom);
      case (phase)
        0: s_ack_i = ($urandom_range(1) == 1) ? 1'b1 : 1'bz;
        1: s_ack_i = 1'bz;
        default: s_ack_i = ($urandom_range(5) == 0) ? 1'b1 : 1'bz;
      endcase
      #1;
      a = (s_ack_i === 1'b1);
      oc = 0; os = 0; ow = 0; oadr = '0; odat = '0; other_cyc = 0;
      if (owner == 1) begin oc = m0_cyc_i; os = m0_stb_i; ow = m0_we_i; oadr = m0_adr_i; odat = m0_dat_i; other_cyc = m1_cyc_i; end
      if (owner == 2) begin oc = m1_cyc_i; os = m1_stb_i; ow = m1_we_i; oadr = m1_adr_i; odat = m1_dat_i; other_cyc = m0_cyc_i; end
      act = oc;
      to  = act && os && !a && (wd == TIMEOUT - 1);
      exp = {(owner == 2) ? 1'b1 : 1'b0, (owner == 1) ? 1'b1 : 1'b0,
             act, act && os && !to, act && ow,
             act ? oadr : 16'h0000, act ? odat : 8'h00,
             owner == 1 && act && os && a, owner == 1 && to,
             owner == 2 && act && os && a, owner == 2 && to,
             s_dat_i, s_dat_i};
      got = {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL random_cyc%0d: got %h want %h", n, got, exp); end
      // Advance the reference model across the coming edge.
      if (owner == 0) begin
        if (m0_cyc_i && m1_cyc_i) owner = (last == 1) ? 1 : 2;
        else if (m0_cyc_i) owner = 1;
        else if (m1_cyc_i) owner = 2;
        wd = 0;
      end else if (!oc) begin
        last  = owner - 1;
        owner = other_cyc ? 3 - owner : 0;
        wd    = 0;
      end else begin
        wd = (os && !a && !to) ? wd + 1 : 0;
      end
      clk_step();
    end
    clear_inputs();
    clk_step(); clk_step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_hold();
    test_timeout();
    test_ack_edge();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter2.md
Name: wishbone_arbiter2

Overview:
- Two-master, single-bus Wishbone arbiter.
- Lets a CPU-side master (m0) and a DMA/test master (m1) share one Wishbone segment to the 8-bit address-decoded memory slaves.
- Round-robin grant, held for a whole bus cycle (cyc).
- A watchdog ends strobes that no slave acknowledges, such as unmapped addresses where no slave drives ack, and signals an error to the owning master.

Parameters:
- TIMEOUT, 15, cycles of stb-without-ack before error; legal range 1..255.
- CNT_W, 8, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- m0_adr_i  in  16  master 0 address.
- m0_we_i  in  1  master 0 write enable.
- m0_stb_i  in  1  master 0 strobe.
- m0_cyc_i  in  1  master 0 cycle / bus request.
- m0_dat_i  in  8  master 0 write data.
- m0_dat_o  out  8  master 0 read data.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_err_o  out  1  master 0 timeout error.
- m1_*  same set as m0_*, for master 1.
- s_adr_o  out  16  shared bus address.
- s_we_o  out  1  shared bus write enable.
- s_stb_o  out  1  shared bus strobe.
- s_cyc_o  out  1  shared bus cycle.
- s_dat_o  out  8  shared bus write data.
- s_dat_i  in  8  shared bus read data.
- s_ack_i  in  1  shared bus acknowledge; counts as asserted only when exactly 1 (Z/X = no ack).
- gnt_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 = idle.

Behaviour:
- States:
  - IDLE, GNT0, GNT1.
  - last_gnt register resets to 1, so m0 wins the first tie.
- Reset (rst_i low, asynchronous):
  - State goes to IDLE, last_gnt=1, watchdog=0.
  - gnt_o=00.
  - All s_* outputs are 0.
  - All m*_ack_o and m*_err_o are 0.
  - m*_dat_o follow s_dat_i.
  - A transfer in progress is abandoned with no ack and no err.
- IDLE:
  - Only m0_cyc_i high → GNT0.
  - Only m1_cyc_i high → GNT1.
  - Both high → the master not equal to last_gnt.
  - Neither high → stay.
  - Grant latency: exactly 1 clock from cyc asserted to gnt_o/s_cyc_o.
- GNTn:
  - s_adr_o, s_we_o, s_stb_o, s_cyc_o and s_dat_o are combinationally muxed from master n.
  - mn_ack_o = s_ack_i & mn_stb_i, same cycle (zero added latency).
  - The other master sees ack=0 and err=0.
  - Both m0_dat_o and m1_dat_o always equal s_dat_i.
  - Grant is held while mn_cyc_i=1; stb may pulse several times (block transfers).
- Release, when mn_cyc_i=0 in GNTn:
  - last_gnt <= n.
  - If the other master's cyc is high, go directly to its grant state with no idle cycle; otherwise go to IDLE.
  - The bus is driven to 0 on the cycle cyc drops.
- Watchdog:
  - Increments each clock in a GNT state with s_stb_o=1 and no ack.
  - Clears on ack, on stb low, or on a state change.
  - When the count equals TIMEOUT-1 and still no ack: mn_err_o=1 for exactly 1 cycle (the TIMEOUT-th strobe cycle), s_stb_o forced to 0 that cycle, and the counter clears.
  - Ack and err are never asserted together.
  - Ack arriving on the same cycle as the timeout: ack wins, no err.
- Counter saturates and never wraps; it cannot exceed TIMEOUT-1.
- Mid-cycle request from the other master has no effect until the owner drops cyc (no preemption).

Test Plan:
- Reset mid-transfer: m0 granted, stb=1, drop rst_i asynchronously between edges → gnt_o=00, s_cyc_o=0, m0_ack_o=0 immediately without waiting for a clock edge.
- Single master: m1_cyc/stb=1, m1_adr=16'h1A05, we=1, dat=8'h5C → gnt_o=10 one clock later; s_adr_o=1A05, s_dat_o=5C; slave ack → m1_ack_o=1 same cycle.
- Simultaneous request after reset: both cyc=1 → gnt_o=01 (m0). m0 drops cyc → gnt_o=10 on the next clock with no idle cycle. m1 drops, then both request again → m0 granted.
- Hold: m0 granted, m1 requests, m0 does 3 stb/ack reads returning 8'h11, 8'h22, 8'h33 → m0_dat_o sees each value; m1 never acked; m1 granted only after m0_cyc drops.
- Timeout: m0 strobes adr 16'hF000, s_ack_i=Z, TIMEOUT=15 → m0_err_o=1 for one cycle on the 15th stb cycle, s_stb_o=0 that cycle, m0_ack_o stays 0.
- Ack vs. watchdog edge: ack on the 15th cycle → m0_ack_o=1, m0_err_o=0, watchdog=0.
